// File: rtl/fifo_fwft.sv
// fifo_fwft: single-clock first-word-fall-through FIFO with valid/ready handshakes, level and almost flags
// Ports: clk, rst_n (async active-low), flush_i (sync clear);
//        write side wr_data_i/wr_valid_i/wr_ready_o; read side rd_data_o/rd_valid_o/rd_ready_i;
//        level_o (0..DEPTH), almost_full_o (level >= AFULL_LEVEL), almost_empty_o (level <= AEMPTY_LEVEL)
module fifo_fwft #(
  parameter int DEPTH_WIDTH  = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int AFULL_LEVEL  = 2**DEPTH_WIDTH - 2,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush_i,
  input  logic [(DATA_WIDTH<1?1:DATA_WIDTH)-1:0]    wr_data_i,
  input  logic                                      wr_valid_i,
  output logic                                      wr_ready_o,
  output logic [(DATA_WIDTH<1?1:DATA_WIDTH)-1:0]    rd_data_o,
  output logic                                      rd_valid_o,
  input  logic                                      rd_ready_i,
  output logic [(DEPTH_WIDTH<1?1:DEPTH_WIDTH):0]    level_o,
  output logic                                      almost_full_o,
  output logic                                      almost_empty_o
);
  localparam int AW = DEPTH_WIDTH < 1 ? 1 : DEPTH_WIDTH;
  localparam int DW = DATA_WIDTH < 1 ? 1 : DATA_WIDTH;
  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] AF = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0] AE = (AW+1)'(AEMPTY_LEVEL);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, level_next;
  logic full, empty, wr_xfer, rd_xfer;
  // pointers carry one extra bit so equal low bits with differing MSB means full
  always_comb begin
    level_o = wptr - rptr;
    empty = wptr == rptr;
    full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    wr_ready_o = !full && !flush_i;
    rd_valid_o = !empty && !flush_i;
    rd_data_o = empty ? '0 : mem[rptr[AW-1:0]];
    wr_xfer = wr_valid_i && wr_ready_o;
    rd_xfer = rd_valid_o && rd_ready_i;
    level_next = flush_i ? '0 : level_o + (AW+1)'(wr_xfer) - (AW+1)'(rd_xfer);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      almost_full_o <= AFULL_LEVEL == 0;
      almost_empty_o <= 1'b1;
    end else begin
      wptr <= flush_i ? '0 : wptr + (AW+1)'(wr_xfer);
      rptr <= flush_i ? '0 : rptr + (AW+1)'(rd_xfer);
      almost_full_o <= level_next >= AF;
      almost_empty_o <= level_next <= AE;
    end
  always_ff @(posedge clk)
    if (wr_xfer) mem[wptr[AW-1:0]] <= wr_data_i;
endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: randomized and directed scoreboard bench for fifo_fwft against a queue model
module tb_fifo_fwft;
  localparam int DEPTH = 4;
  localparam int AFL = 2;
  localparam int AEL = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic wr_valid_i = 1'b0;
  logic rd_ready_i = 1'b0;
  logic wr_ready_o, rd_valid_o, almost_full_o, almost_empty_o;
  logic [31:0] rd_data_o;
  logic [2:0] level_o;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] sb [$];
  fifo_fwft #(.DEPTH_WIDTH(2), .DATA_WIDTH(32), .AFULL_LEVEL(AFL), .AEMPTY_LEVEL(AEL)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .level_o(level_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " wr_ready"}, 32'(wr_ready_o), 32'd1);
    chk({tag, " rd_valid"}, 32'(rd_valid_o), 32'd0);
    chk({tag, " rd_data"}, rd_data_o, 32'd0);
    chk({tag, " level"}, 32'(level_o), 32'd0);
    chk({tag, " almost_full"}, 32'(almost_full_o), 32'd0);
    chk({tag, " almost_empty"}, 32'(almost_empty_o), 32'd1);
  endtask
  // monitor: inputs change at the falling edge, outputs are sampled 2 time units later
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      chk_reset("reset");
      sb.delete();
    end else begin
      automatic int n = sb.size();
      automatic logic exp_wr = (n < DEPTH) && !flush_i;
      automatic logic exp_rv = (n != 0) && !flush_i;
      chk("wr_ready", 32'(wr_ready_o), 32'(exp_wr));
      chk("rd_valid", 32'(rd_valid_o), 32'(exp_rv));
      chk("level", 32'(level_o), 32'(n));
      chk("almost_full", 32'(almost_full_o), 32'(n >= AFL));
      chk("almost_empty", 32'(almost_empty_o), 32'(n <= AEL));
      if (exp_rv) chk("rd_data", rd_data_o, sb[0]);
      if (flush_i) sb.delete();
      else begin
        if (exp_rv && rd_ready_i) void'(sb.pop_front());
        if (exp_wr && wr_valid_i) sb.push_back(wr_data_i);
      end
    end
  end
  task automatic step(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
    @(negedge clk);
    wr_valid_i = wv;
    wr_data_i = wd;
    rd_ready_i = rr;
    flush_i = fl;
  endtask
  initial begin
    repeat (2) step(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 0, 0);
    step(1, 32'h33, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) step(1, 32'(i), 0, 0);
    step(1, 32'h66, 1, 0);
    step(1, 32'h77, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    for (int i = 0; i < 100; i++) step(1, 32'h1000 + 32'(i), 1, 0);
    repeat (2) step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h50 + 32'(i), 0, 0);
    step(1, 32'h99, 1, 1);
    step(0, 0, 1, 0);
    step(1, 32'hAB, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 32'hC1, 0, 0);
    step(1, 32'hC2, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async reset");
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 32'hD0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
